// File: rtl/weight_sched_pkg.sv
// Shared constants, state encodings and helpers for the weight tile scheduler.
// Stream words carry 8 int8 weights, so row lengths are converted to words with a ceil-div by 8.
package weight_sched_pkg;

    localparam int PE_COLS_DEF = 8;
    localparam int WORD_SHIFT  = 3;
    localparam int COLS_W      = 4;
    localparam int SB_ADDR_W   = 9;

    typedef enum logic [1:0] {
        LD_IDLE      = 2'd0,
        LD_LOAD      = 2'd1,
        LD_WAIT_BANK = 2'd2
    } load_state_e;

    typedef enum logic [1:0] {
        CP_IDLE  = 2'd0,
        CP_ISSUE = 2'd1,
        CP_RUN   = 2'd2
    } comp_state_e;

    function automatic logic [31:0] ceil_div8(input logic [31:0] x);
        return (x + 32'd7) >> WORD_SHIFT;
    endfunction

endpackage

// File: rtl/sb_addr_gen.sv
// Scale/bias address sequencer: after a start pulse, reads count consecutive
// addresses beginning at base, one per cycle.
module sb_addr_gen
    import weight_sched_pkg::*;
#(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int CNT_W  = COLS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic              sb_rd_o,
    output logic [ADDR_W-1:0] sb_addr_o,
    output logic              busy_o
);

    logic              rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  left_q;

    // Walk the address window; left_q counts reads still owed after the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= 1'b0;
            addr_q <= '0;
            left_q <= '0;
        end else if (start_i && (count_i != '0)) begin
            rd_q   <= 1'b1;
            addr_q <= base_i;
            left_q <= count_i - CNT_W'(1);
        end else if (rd_q && (left_q != '0)) begin
            addr_q <= addr_q + ADDR_W'(1);
            left_q <= left_q - CNT_W'(1);
        end else begin
            rd_q <= 1'b0;
        end
    end

    assign sb_rd_o   = rd_q;
    assign sb_addr_o = addr_q;
    assign busy_o    = rd_q | start_i;

endmodule

// File: rtl/weight_tile_scheduler.sv
// Ping-pong weight tile scheduler: streams tiles of weights into a two-bank cache
// while the PE array computes on the other bank, and sequences scale/bias reads.
module weight_tile_scheduler
    import weight_sched_pkg::*;
#(
    parameter int PE_COLS = PE_COLS_DEF,
    parameter int DATA_W  = 64,
    parameter int DIM_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM_W-1:0]     matrix_row,
    input  logic [DIM_W-1:0]     matrix_col,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 wc_valid,
    input  logic                 wc_ready,
    output logic [DATA_W-1:0]    wc_data,
    output logic                 wc_bank,
    output logic                 comp_start,
    output logic                 comp_bank,
    output logic [COLS_W-1:0]    comp_cols,
    input  logic                 comp_done,
    output logic                 sb_rd,
    output logic [SB_ADDR_W-1:0] sb_addr,
    output logic                 busy,
    output logic                 layer_done
);

    localparam int CNT_W = DIM_W + 8;

    load_state_e        load_st_q;
    comp_state_e        comp_st_q;
    logic [1:0]         bank_full_q, bank_full_d;
    logic               load_bank_q, comp_bank_q;
    logic [DIM_W-1:0]   load_tile_q, comp_tile_q, tiles_q;
    logic [CNT_W-1:0]   word_cnt_q, wpc_q;
    logic [COLS_W-1:0]  last_cols_q, comp_cols_q;
    logic               busy_q, layer_done_q, comp_start_q;

    logic               loading_s, start_acc_s, zero_dim_s, xfer_s, last_word_s;
    logic               run_done_s, final_s, sb_busy_s;
    logic [COLS_W-1:0]  ld_cols_s, cp_cols_s;
    logic [CNT_W-1:0]   ld_words_s;
    logic [31:0]        tiles_calc_s, last_cols_calc_s;
    logic [1:0]         set_mask_s, clr_mask_s;
    logic [SB_ADDR_W-1:0] sb_base_s;

    assign loading_s   = (load_st_q == LD_LOAD);
    assign start_acc_s = start & ~busy_q;
    assign zero_dim_s  = (matrix_row == '0) || (matrix_col == '0);
    assign xfer_s      = in_valid & wc_ready & loading_s;
    assign run_done_s  = (comp_st_q == CP_RUN) && comp_done;
    assign final_s     = run_done_s && (comp_tile_q == tiles_q - DIM_W'(1));

    assign tiles_calc_s     = (32'(matrix_col) + 32'(PE_COLS) - 32'd1) / 32'(PE_COLS);
    assign last_cols_calc_s = 32'(matrix_col) - (tiles_calc_s - 32'd1) * 32'(PE_COLS);

    assign ld_cols_s   = (load_tile_q == tiles_q - DIM_W'(1)) ? last_cols_q : COLS_W'(PE_COLS);
    assign cp_cols_s   = (comp_tile_q == tiles_q - DIM_W'(1)) ? last_cols_q : COLS_W'(PE_COLS);
    assign ld_words_s  = wpc_q * CNT_W'(ld_cols_s);
    assign last_word_s = xfer_s && (word_cnt_q == ld_words_s - CNT_W'(1));

    // A bank is filled by the load side and drained by the compute side, never the same bank at once.
    assign set_mask_s  = last_word_s ? (2'b01 << load_bank_q) : 2'b00;
    assign clr_mask_s  = run_done_s  ? (2'b01 << comp_bank_q) : 2'b00;
    assign bank_full_d = (bank_full_q | set_mask_s) & ~clr_mask_s;
    assign sb_base_s   = SB_ADDR_W'(32'(comp_tile_q) * 32'(PE_COLS));

    // Layer bookkeeping: dimensions, bank occupancy, busy and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
            bank_full_q  <= 2'b00;
            wpc_q        <= '0;
            tiles_q      <= '0;
            last_cols_q  <= '0;
        end else begin
            bank_full_q  <= start_acc_s ? 2'b00 : bank_full_d;
            layer_done_q <= (start_acc_s && zero_dim_s) || final_s;
            if (layer_done_q) begin
                busy_q <= 1'b0;
            end else if (start_acc_s) begin
                busy_q <= 1'b1;
            end
            if (start_acc_s) begin
                wpc_q       <= CNT_W'(ceil_div8(32'(matrix_row)));
                tiles_q     <= DIM_W'(tiles_calc_s);
                last_cols_q <= COLS_W'(last_cols_calc_s);
            end
        end
    end

    // Load FSM: one tile per bank, stalling when the next bank still holds an uncomputed tile.
    always_ff @(posedge clk) begin
        if (rst || final_s) begin
            load_st_q   <= LD_IDLE;
            load_bank_q <= 1'b0;
            load_tile_q <= '0;
            word_cnt_q  <= '0;
        end else begin
            case (load_st_q)
                LD_IDLE: begin
                    if (start_acc_s && !zero_dim_s) begin
                        load_st_q   <= LD_LOAD;
                        load_bank_q <= 1'b0;
                        load_tile_q <= '0;
                        word_cnt_q  <= '0;
                    end
                end
                LD_LOAD: begin
                    if (last_word_s) begin
                        word_cnt_q  <= '0;
                        load_bank_q <= ~load_bank_q;
                        load_tile_q <= load_tile_q + DIM_W'(1);
                        if (load_tile_q == tiles_q - DIM_W'(1)) begin
                            load_st_q <= LD_IDLE;
                        end else if (bank_full_d[~load_bank_q]) begin
                            load_st_q <= LD_WAIT_BANK;
                        end
                    end else if (xfer_s) begin
                        word_cnt_q <= word_cnt_q + CNT_W'(1);
                    end
                end
                LD_WAIT_BANK: begin
                    if (!bank_full_q[load_bank_q]) begin
                        load_st_q <= LD_LOAD;
                    end
                end
                default: load_st_q <= LD_IDLE;
            endcase
        end
    end

    // Compute FSM: issue each resident tile once the previous scale/bias burst has drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            comp_st_q    <= CP_IDLE;
            comp_bank_q  <= 1'b0;
            comp_tile_q  <= '0;
            comp_start_q <= 1'b0;
            comp_cols_q  <= '0;
        end else begin
            comp_start_q <= 1'b0;
            case (comp_st_q)
                CP_IDLE: begin
                    if (start_acc_s && !zero_dim_s) begin
                        comp_st_q   <= CP_ISSUE;
                        comp_bank_q <= 1'b0;
                        comp_tile_q <= '0;
                    end
                end
                CP_ISSUE: begin
                    if (bank_full_q[comp_bank_q] && !sb_busy_s) begin
                        comp_start_q <= 1'b1;
                        comp_cols_q  <= cp_cols_s;
                        comp_st_q    <= CP_RUN;
                    end
                end
                CP_RUN: begin
                    if (comp_done) begin
                        comp_bank_q <= ~comp_bank_q;
                        comp_tile_q <= comp_tile_q + DIM_W'(1);
                        comp_st_q   <= final_s ? CP_IDLE : CP_ISSUE;
                    end
                end
                default: comp_st_q <= CP_IDLE;
            endcase
        end
    end

    sb_addr_gen #(
        .ADDR_W (SB_ADDR_W),
        .CNT_W  (COLS_W)
    ) u_sb_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .start_i   (comp_start_q),
        .base_i    (sb_base_s),
        .count_i   (comp_cols_q),
        .sb_rd_o   (sb_rd),
        .sb_addr_o (sb_addr),
        .busy_o    (sb_busy_s)
    );

    assign in_ready   = wc_ready & loading_s;
    assign wc_valid   = in_valid & loading_s;
    assign wc_data    = in_data;
    assign wc_bank    = load_bank_q;
    assign comp_start = comp_start_q;
    assign comp_bank  = comp_bank_q;
    assign comp_cols  = comp_cols_q;
    assign busy       = busy_q;
    assign layer_done = layer_done_q;

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// Directed-plus-random bench for weight_tile_scheduler against a tile-level reference model.
module tb_weight_tile_scheduler;

    localparam int PE = 8;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, wc_ready, comp_done;
    logic [15:0] matrix_row, matrix_col;
    logic [63:0] in_data;
    logic        in_ready, wc_valid, wc_bank, comp_start, comp_bank, sb_rd, busy, layer_done;
    logic [63:0] wc_data;
    logic [3:0]  comp_cols;
    logic [8:0]  sb_addr;

    weight_tile_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .matrix_row(matrix_row), .matrix_col(matrix_col),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wc_valid(wc_valid), .wc_ready(wc_ready), .wc_data(wc_data), .wc_bank(wc_bank),
        .comp_start(comp_start), .comp_bank(comp_bank), .comp_cols(comp_cols), .comp_done(comp_done),
        .sb_rd(sb_rd), .sb_addr(sb_addr), .busy(busy), .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    // reference model state
    int  wpc_m, t_m, col_m, ld_tile_m, ld_word_m, cp_tile_m, done_m, timer;
    int  words_m, starts_m, sb_total, ld_cnt_m, sb_left, sb_addr_m, wait_cyc, cyc_m, ld_seen_cyc;
    int  rdy_pct, val_pct, done_dly;
    bit  active_m, busy_exp, ld_exp, outstanding, hold_valid, stray;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cols_of(input int t);
        return (t < t_m - 1) ? PE : col_m - (t_m - 1) * PE;
    endfunction

    function automatic int words_of(input int t);
        return wpc_m * cols_of(t);
    endfunction

    task automatic model_clear();
        busy_exp = 1'b0; ld_exp = 1'b0; active_m = 1'b0; outstanding = 1'b0; hold_valid = 1'b0;
        t_m = 0; sb_left = 0; ld_tile_m = 0; ld_word_m = 0; cp_tile_m = 0; done_m = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; comp_done = 1'b0; in_valid = 1'b1; wc_ready = 1'b1;
        in_data = 64'hFFFF_FFFF_FFFF_FFFF; matrix_row = 16'd8; matrix_col = 16'd8;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_wc_valid", wc_valid, 1'b0);
        chk("rst_comp_start", comp_start, 1'b0);
        chk("rst_sb_rd", sb_rd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_layer_done", layer_done, 1'b0);
        chk("rst_sb_addr", sb_addr, 9'd0);
        chk("rst_comp_cols", comp_cols, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // One clock: check registered outputs, drive new inputs, check the handshake, advance the model.
    task automatic step(input bit st);
        bit acc, nxt_ld;
        @(negedge clk);
        cyc_m++;
        chk("layer_done", layer_done, ld_exp);
        if (layer_done) begin ld_cnt_m++; ld_seen_cyc = cyc_m; end
        chk("busy", busy, busy_exp);
        chk("sb_rd", sb_rd, sb_left > 0);
        if (sb_left > 0) begin
            chk("sb_addr", sb_addr, sb_addr_m);
            sb_addr_m++; sb_left--; sb_total++;
        end
        if (comp_start) begin
            chk("comp_start_legal", active_m && !outstanding && cp_tile_m < t_m && ld_tile_m > cp_tile_m, 1'b1);
            chk("comp_cols", comp_cols, cols_of(cp_tile_m));
            chk("comp_bank", comp_bank, cp_tile_m % 2);
            sb_left = cols_of(cp_tile_m); sb_addr_m = cp_tile_m * PE;
            outstanding = 1'b1; timer = done_dly; cp_tile_m++; starts_m++;
        end
        start = st;
        comp_done = stray;
        if (outstanding) begin
            if (timer == 0) comp_done = 1'b1;
            else timer--;
        end
        if (!hold_valid) begin
            in_valid = ($urandom_range(99) < val_pct);
            if (in_valid) in_data = {$urandom, $urandom};
        end
        wc_ready = ($urandom_range(99) < rdy_pct);
        #1;
        if (active_m && ld_tile_m < t_m && ld_tile_m >= done_m + 2) wait_cyc++;
        if (in_ready) begin
            chk("ready_allowed", active_m && ld_tile_m < t_m && ld_tile_m < done_m + 2, 1'b1);
            chk("wc_valid_pass", wc_valid, in_valid);
        end else if (wc_ready) begin
            chk("wc_valid_gated", wc_valid, 1'b0);
        end
        if (in_valid && in_ready) begin
            chk("wc_data", wc_data, in_data);
            chk("wc_bank", wc_bank, ld_tile_m % 2);
            hold_valid = 1'b0;
            words_m++; ld_word_m++;
            if (ld_word_m == words_of(ld_tile_m)) begin ld_tile_m++; ld_word_m = 0; end
        end else begin
            hold_valid = in_valid;
        end
        acc = st && !busy_exp;
        nxt_ld = 1'b0;
        if (comp_done && outstanding) begin
            outstanding = 1'b0; done_m++;
            if (done_m == t_m) begin nxt_ld = 1'b1; active_m = 1'b0; end
        end
        if (acc) begin
            col_m = matrix_col; wpc_m = (matrix_row + 7) / 8; t_m = (matrix_col + PE - 1) / PE;
            ld_tile_m = 0; ld_word_m = 0; cp_tile_m = 0; done_m = 0;
            active_m = (matrix_row != 16'd0) && (matrix_col != 16'd0);
            if (!active_m) begin t_m = 0; nxt_ld = 1'b1; end
        end
        busy_exp = ld_exp ? 1'b0 : (busy_exp | acc);
        ld_exp = nxt_ld;
    endtask

    task automatic run_layer(input int row, input int col, input int rdy, input int val,
                             input int dly, input int budget, input int spur);
        int exp_words, exp_tiles;
        matrix_row = 16'(row); matrix_col = 16'(col);
        rdy_pct = rdy; val_pct = val; done_dly = dly;
        words_m = 0; starts_m = 0; sb_total = 0; ld_cnt_m = 0; wait_cyc = 0; cyc_m = -1; ld_seen_cyc = -1;
        step(1'b1);
        for (int i = 1; i < budget && ld_cnt_m == 0; i++) begin
            if (i == spur) begin matrix_row = 16'd8; matrix_col = 16'd1; end
            step(i == spur);
        end
        repeat (4) step(1'b0);
        exp_words = (row != 0 && col != 0) ? ((row + 7) / 8) * col : 0;
        exp_tiles = (row != 0 && col != 0) ? (col + PE - 1) / PE : 0;
        chk("total_words", words_m, exp_words);
        chk("comp_start_count", starts_m, exp_tiles);
        chk("sb_read_count", sb_total, (exp_tiles != 0) ? col : 0);
        chk("layer_done_count", ld_cnt_m, 1);
    endtask

    initial begin
        stray = 1'b0;
        apply_reset();
        repeat (3) step(1'b0);

        // full layer, no backpressure
        run_layer(432, 35, 100, 100, 12, 5000, -1);

        // slow array: loader must stall on the occupied bank
        run_layer(432, 35, 100, 100, 2000, 20000, -1);
        chk("wait_bank_stall", wait_cyc > 1000, 1'b1);

        // random cache backpressure and source gaps
        run_layer(100, 20, 50, 70, 12, 20000, -1);

        // degenerate dimensions
        run_layer(5, 0, 100, 100, 12, 50, -1);
        chk("zero_col_latency", ld_seen_cyc, 1);
        run_layer(0, 9, 100, 100, 12, 50, -1);
        chk("zero_row_latency", ld_seen_cyc, 1);

        // reset in the middle of tile 2 load, then a small fresh layer
        matrix_row = 16'd432; matrix_col = 16'd35; rdy_pct = 100; val_pct = 100; done_dly = 12;
        ld_cnt_m = 0;
        step(1'b1);
        for (int i = 0; i < 5000 && !(ld_tile_m == 2 && ld_word_m >= 20); i++) step(1'b0);
        chk("reached_tile2", ld_tile_m, 2);
        apply_reset();
        repeat (5) step(1'b0);
        chk("abort_no_layer_done", ld_cnt_m, 0);
        run_layer(16, 8, 100, 100, 12, 2000, -1);

        // start while busy, then stray comp_done pulses while idle
        run_layer(100, 20, 100, 100, 12, 5000, 50);
        stray = 1'b1;
        repeat (5) step(1'b0);
        stray = 1'b0;
        repeat (3) step(1'b0);
        chk("stray_layer_done_count", ld_cnt_m, 1);
        chk("stray_comp_start_count", starts_m, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
